// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory freeze, mul/div wait,
// branch flush and load-use bubbles, and keeps saturating stall/flush performance counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             case_A1,
    input  logic             case_A2,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT, ERR} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic            md_pending, md_pending_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            mem_stall, load_use;
    logic            sel_freeze, sel_md, sel_branch, sel_load_use, lower_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_stall = dmem_req & ~dmem_ack;
    assign load_use  = ex_is_load & (case_A1 | case_A2);
    assign mem_err   = (state == ERR);

    always_comb begin
        state_nxt      = state;
        md_pending_nxt = md_pending;
        to_cnt_nxt     = to_cnt;
        sel_freeze     = 1'b0;
        sel_md         = 1'b0;
        lower_ok       = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    sel_freeze     = 1'b1;
                    state_nxt      = MEM_WAIT;
                    to_cnt_nxt     = '0;
                    md_pending_nxt = 1'b0;
                end else if (md_start && !md_done) begin
                    sel_md    = 1'b1;
                    state_nxt = MD_WAIT;
                end else begin
                    // md_start with md_done in the same cycle is a zero-wait op
                    lower_ok = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack) begin
                    sel_freeze     = 1'b1;
                    md_pending_nxt = md_pending & ~md_done;
                    if (to_cnt == TO_LAST) state_nxt = ERR;
                    else                   to_cnt_nxt = to_cnt + TO_W'(1);
                end else begin
                    to_cnt_nxt     = '0;
                    md_pending_nxt = 1'b0;
                    if (md_pending && !md_done) begin
                        sel_md    = 1'b1;
                        state_nxt = MD_WAIT;
                    end else begin
                        state_nxt = RUN;
                        lower_ok  = 1'b1;
                    end
                end
            end
            MD_WAIT: begin
                if (mem_stall) begin
                    sel_freeze     = 1'b1;
                    state_nxt      = MEM_WAIT;
                    to_cnt_nxt     = '0;
                    md_pending_nxt = ~md_done;
                end else if (!md_done) begin
                    sel_md = 1'b1;
                end else begin
                    state_nxt = RUN;
                    lower_ok  = 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: state_nxt = RUN;
        endcase
        sel_branch   = lower_ok & branch_taken;
        sel_load_use = lower_ok & ~branch_taken & load_use;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
        end else if (state == ERR || sel_freeze) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        end else if (sel_md) begin
            // Hold the front end, let older work drain, bubble EX/MEM
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (sel_branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (sel_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            md_pending   <= 1'b0;
            to_cnt       <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state      <= state_nxt;
            md_pending <= md_pending_nxt;
            to_cnt     <= to_cnt_nxt;
            if (!pc_en)     stall_cycles <= sat_inc(stall_cycles);
            if (sel_branch) flush_count  <= sat_inc(flush_count);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: main instance with a short memory timeout,
// second instance with 2-bit counters for saturation.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, case_A1, case_A2, ex_is_load, branch_taken;
    logic dmem_req, dmem_ack, md_start, md_done;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
    logic [15:0] stall_cycles, flush_count;

    logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_err;
    logic [1:0] s_stall_cycles, s_flush_count;

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_ex_flush, ex_mem_flush};

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4), .TO_W(3)) dut (
        .clk(clk), .reset(reset), .case_A1(case_A1), .case_A2(case_A2),
        .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .md_start(md_start), .md_done(md_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_stall_ctrl #(.CNT_W(2), .MEM_TIMEOUT(64), .TO_W(7)) dut_sat (
        .clk(clk), .reset(reset), .case_A1(case_A1), .case_A2(case_A2),
        .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .md_start(md_start), .md_done(md_done),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
        .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .mem_err(s_mem_err),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        case_A1 = 0; case_A2 = 0; ex_is_load = 0; branch_taken = 0;
        dmem_req = 0; dmem_ack = 0; md_start = 0; md_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #1;
        check("rst_en", en, 5'b00000);
        check("rst_flush", fl, 3'b111);
        cyc();
        reset = 0;
        #1;
        check("rst_stall_cnt", stall_cycles, 0);
        check("rst_flush_cnt", flush_count, 0);
        check("rst_mem_err", mem_err, 0);
        check("normal_en", en, 5'b11111);
        check("normal_flush", fl, 3'b000);

        // load-use: one-cycle bubble into ID/EX
        do_reset();
        ex_is_load = 1; case_A1 = 1; #1;
        check("lu_en", en, 5'b00111);
        check("lu_flush", fl, 3'b010);
        cyc();
        clear_inputs(); #1;
        check("lu_after_en", en, 5'b11111);
        check("lu_after_flush", fl, 3'b000);
        check("lu_stall_cnt", stall_cycles, 1);

        // branch wins over load-use
        do_reset();
        branch_taken = 1; ex_is_load = 1; case_A2 = 1; #1;
        check("br_lu_en", en, 5'b11111);
        check("br_lu_flush", fl, 3'b110);
        cyc();
        clear_inputs(); #1;
        check("br_lu_flush_cnt", flush_count, 1);
        check("br_lu_stall_cnt", stall_cycles, 0);

        // memory wait: three frozen cycles, release on ack
        do_reset();
        dmem_req = 1; #1;
        for (int i = 0; i < 3; i++) begin
            check("mw_freeze_en", en, 5'b00000);
            check("mw_freeze_flush", fl, 3'b000);
            cyc();
        end
        dmem_ack = 1; #1;
        check("mw_ack_en", en, 5'b11111);
        cyc();
        clear_inputs(); #1;
        check("mw_run_en", en, 5'b11111);
        check("mw_stall_cnt", stall_cycles, 3);

        // mul/div with a memory stall in the middle
        do_reset();
        md_start = 1; #1;
        check("md_start_en", en, 5'b00011);
        check("md_start_flush", fl, 3'b001);
        cyc();
        md_start = 0; #1;
        for (int i = 0; i < 2; i++) begin
            check("md_wait_en", en, 5'b00011);
            check("md_wait_flush", fl, 3'b001);
            cyc();
        end
        dmem_req = 1; #1;
        for (int i = 0; i < 2; i++) begin
            check("md_freeze_en", en, 5'b00000);
            check("md_freeze_flush", fl, 3'b000);
            cyc();
        end
        dmem_ack = 1; #1;
        check("md_ack_en", en, 5'b00011);
        check("md_ack_flush", fl, 3'b001);
        cyc();
        dmem_req = 0; dmem_ack = 0; md_done = 1; #1;
        check("md_done_en", en, 5'b11111);
        check("md_done_flush", fl, 3'b000);
        cyc();
        md_done = 0; #1;
        check("md_run_en", en, 5'b11111);
        check("md_stall_cnt", stall_cycles, 6);

        // spurious md_done, then zero-wait start+done
        md_done = 1; #1;
        check("md_spurious_en", en, 5'b11111);
        cyc();
        md_start = 1; #1;
        check("md_zero_wait_en", en, 5'b11111);
        check("md_zero_wait_flush", fl, 3'b000);
        cyc();
        clear_inputs(); #1;
        check("md_zero_wait_next_en", en, 5'b11111);
        check("md_zero_wait_stall_cnt", stall_cycles, 6);

        // timeout: ERR after four MEM_WAIT cycles without ack
        do_reset();
        dmem_req = 1; #1;
        for (int i = 0; i < 5; i++) begin
            check("to_pre_err", mem_err, 0);
            cyc();
        end
        check("to_mem_err", mem_err, 1);
        check("to_err_en", en, 5'b00000);
        check("to_err_flush", fl, 3'b000);
        dmem_req = 0; dmem_ack = 1; branch_taken = 1;
        cyc(); cyc();
        check("to_err_sticky", mem_err, 1);
        check("to_err_sticky_en", en, 5'b00000);
        clear_inputs();
        reset = 1; #1;
        check("to_rst_en", en, 5'b00000);
        check("to_rst_flush", fl, 3'b111);
        cyc();
        reset = 0; #1;
        check("to_rst_mem_err", mem_err, 0);
        check("to_rst_stall_cnt", stall_cycles, 0);
        check("to_rst_flush_cnt", flush_count, 0);
        check("to_rst_en_after", en, 5'b11111);
        check("to_rst_flush_after", fl, 3'b000);

        // saturation: five branch flushes into a 2-bit counter
        do_reset();
        branch_taken = 1;
        for (int i = 0; i < 5; i++) cyc();
        clear_inputs(); #1;
        check("sat_flush_cnt", s_flush_count, 3);
        check("wide_flush_cnt", flush_count, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
